// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC thermometer/pop-count path.
package tdc_pkg;

    localparam int TCG_MAX_N = 256;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} tcg_state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

    // Bits [min(k,n)-1:0] set; callers narrow the result to their own width.
    function automatic logic [TCG_MAX_N-1:0] therm_of(input int unsigned k, input int unsigned n);
        logic [TCG_MAX_N-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < TCG_MAX_N; i++)
            t[i] = (i < k) && (i < n);
        return t;
    endfunction

endpackage

// File: rtl/tdc_skid_buf.sv
// Two-entry valid/ready buffer; both handshake outputs come straight from flops.
module tdc_skid_buf #(
    parameter int W = 66
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic [W-1:0] head, tail;
    logic [1:0]   cnt, cnt_nxt;
    logic         push, pop;

    assign push   = s_valid && s_ready;
    assign pop    = m_valid && m_ready;
    assign m_data = head;

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + 2'd1;
        else if (!push && pop)
            cnt_nxt = cnt - 2'd1;
    end

    // head is always the oldest word; tail only holds data while two are queued
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 2'd0;
            head    <= '0;
            tail    <= '0;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            cnt     <= cnt_nxt;
            m_valid <= (cnt_nxt != 2'd0);
            s_ready <= (cnt_nxt != 2'd2);
            if (pop && cnt == 2'd2)
                head <= tail;
            else if (push && (cnt == 2'd0 || (pop && cnt == 2'd1)))
                head <= s_data;
            if (push && !pop && cnt == 2'd1)
                tail <= s_data;
        end
    end

endmodule

// File: rtl/therm_code_gen.sv
// Binary count to thermometer word generator with direct and self-sweep modes.
module therm_code_gen import tdc_pkg::*; #(
    parameter  int N          = 64,
    parameter  int SWEEP_STEP = 1,
    localparam int CW         = cnt_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_count,
    input  logic          sweep_start,
    output logic          sweep_busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_therm,
    output logic          out_sat,
    output logic          out_last
);

    localparam int PW = N + 2;

    tcg_state_t    state;
    logic [CW-1:0] k, k_nxt;
    int unsigned   k_sum;
    logic          start_pend;
    logic          buf_rdy, buf_vld, push;
    logic          dir_acc, dir_sat, swp_push, swp_last;
    logic [N-1:0]  dir_therm, swp_therm;
    logic [PW-1:0] push_data, pop_data;

    // A latched start blocks further direct words so the sweep begins next cycle.
    assign in_ready = (state == IDLE) && buf_rdy && !start_pend;
    assign dir_acc  = in_valid && in_ready;
    assign swp_push = (state == SWEEP) && buf_rdy;
    assign dir_sat  = in_count > CW'(N);
    assign swp_last = (k == CW'(N));
    assign push     = dir_acc || swp_push;

    always_comb begin
        dir_therm = N'(therm_of(32'(in_count), N));
        swp_therm = N'(therm_of(32'(k), N));
        k_sum     = 32'(k) + 32'(SWEEP_STEP);
        k_nxt     = (k_sum >= 32'(N)) ? CW'(N) : CW'(k_sum);
        push_data = swp_push ? {swp_therm, 1'b0, swp_last}
                             : {dir_therm, dir_sat, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            start_pend <= 1'b0;
            sweep_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if ((sweep_start || start_pend) && !dir_acc) begin
                        state      <= SWEEP;
                        k          <= '0;
                        start_pend <= 1'b0;
                        sweep_busy <= 1'b1;
                    end else if (sweep_start) begin
                        start_pend <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (swp_push) begin
                        if (swp_last)
                            state <= DRAIN;
                        else
                            k <= k_nxt;
                    end
                end
                DRAIN: begin
                    if (!buf_vld) begin
                        state      <= IDLE;
                        sweep_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    tdc_skid_buf #(.W(PW)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .s_valid (push),
        .s_ready (buf_rdy),
        .s_data  (push_data),
        .m_valid (buf_vld),
        .m_ready (out_ready),
        .m_data  (pop_data)
    );

    assign out_valid                      = buf_vld;
    assign {out_therm, out_sat, out_last} = pop_data;

endmodule

// File: tb/tb_therm_code_gen.sv
// Directed bench for therm_code_gen: N=64/step 1 and N=8/step 3 instances against a queue model.
module tb_therm_code_gen;

    typedef struct {
        logic [63:0] therm;
        logic        sat;
        logic        last;
        int          k;
    } ent_t;

    logic        clk, rst;
    logic        a_in_valid, a_in_ready, a_sweep_start, a_sweep_busy;
    logic        a_out_valid, a_out_ready, a_out_sat, a_out_last;
    logic [6:0]  a_in_count;
    logic [63:0] a_out_therm;
    logic        b_in_valid, b_in_ready, b_sweep_start, b_sweep_busy;
    logic        b_out_valid, b_out_ready, b_out_sat, b_out_last;
    logic [3:0]  b_in_count;
    logic [7:0]  b_out_therm;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t qa[$];
    ent_t qb[$];

    therm_code_gen #(.N(64), .SWEEP_STEP(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_count(a_in_count),
        .sweep_start(a_sweep_start), .sweep_busy(a_sweep_busy), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_therm(a_out_therm), .out_sat(a_out_sat), .out_last(a_out_last)
    );

    therm_code_gen #(.N(8), .SWEEP_STEP(3)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_count(b_in_count),
        .sweep_start(b_sweep_start), .sweep_busy(b_sweep_busy), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_therm(b_out_therm), .out_sat(b_out_sat), .out_last(b_out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected word straight from the decode rule.
    function automatic ent_t mk(input int k, input int n, input logic last);
        ent_t e;
        e.therm = '0;
        for (int i = 0; i < n; i++)
            e.therm[i] = (i < k);
        e.sat  = (k > n);
        e.last = last;
        e.k    = (k > n) ? n : k;
        return e;
    endfunction

    logic        a_hold, b_hold;
    logic [63:0] a_prev_t, b_prev_t;
    logic [1:0]  a_prev_f, b_prev_f;
    int          a_kk, b_kk;
    logic        a_done, b_done;
    ent_t        a_e, b_e;

    // Model for instance A: pop on output handshake, push on input acceptance / sweep start.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            a_hold = 1'b0;
        end else begin
            if (a_hold) begin
                chk("a_hold_valid", 64'(a_out_valid), 64'd1);
                chk("a_hold_therm", a_out_therm, a_prev_t);
                chk("a_hold_flags", 64'({a_out_sat, a_out_last}), 64'(a_prev_f));
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    chk("a_extra_word", 64'(a_out_valid), 64'd0);
                end else begin
                    a_e = qa.pop_front();
                    chk("a_therm", a_out_therm, a_e.therm);
                    chk("a_flags", 64'({a_out_sat, a_out_last}), 64'({a_e.sat, a_e.last}));
                    chk("a_roundtrip", 64'($countones(a_out_therm)), 64'(a_e.k));
                end
            end
            if (a_sweep_busy)
                chk("a_ready_while_busy", 64'(a_in_ready), 64'd0);
            a_hold   = a_out_valid && !a_out_ready;
            a_prev_t = a_out_therm;
            a_prev_f = {a_out_sat, a_out_last};
            if (a_in_valid && a_in_ready)
                qa.push_back(mk(int'(a_in_count), 64, 1'b0));
            if (a_sweep_start && !a_sweep_busy) begin
                a_kk   = 0;
                a_done = 1'b0;
                while (!a_done) begin
                    a_done = (a_kk == 64);
                    qa.push_back(mk(a_kk, 64, a_done));
                    a_kk = (a_kk + 1 > 64) ? 64 : a_kk + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            qb.delete();
            b_hold = 1'b0;
        end else begin
            if (b_hold) begin
                chk("b_hold_valid", 64'(b_out_valid), 64'd1);
                chk("b_hold_therm", 64'(b_out_therm), b_prev_t);
                chk("b_hold_flags", 64'({b_out_sat, b_out_last}), 64'(b_prev_f));
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    chk("b_extra_word", 64'(b_out_valid), 64'd0);
                end else begin
                    b_e = qb.pop_front();
                    chk("b_therm", 64'(b_out_therm), b_e.therm);
                    chk("b_flags", 64'({b_out_sat, b_out_last}), 64'({b_e.sat, b_e.last}));
                    chk("b_roundtrip", 64'($countones(b_out_therm)), 64'(b_e.k));
                end
            end
            if (b_sweep_busy)
                chk("b_ready_while_busy", 64'(b_in_ready), 64'd0);
            b_hold   = b_out_valid && !b_out_ready;
            b_prev_t = 64'(b_out_therm);
            b_prev_f = {b_out_sat, b_out_last};
            if (b_in_valid && b_in_ready)
                qb.push_back(mk(int'(b_in_count), 8, 1'b0));
            if (b_sweep_start && !b_sweep_busy) begin
                b_kk   = 0;
                b_done = 1'b0;
                while (!b_done) begin
                    b_done = (b_kk == 8);
                    qb.push_back(mk(b_kk, 8, b_done));
                    b_kk = (b_kk + 3 > 8) ? 8 : b_kk + 3;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          dirv[6];
    logic [63:0] lit[6];
    logic        satv[6];
    logic [7:0]  got[4];
    int          idx, cyc, nb, lastn;
    logic        acc, saw_full;

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_count = '0; a_sweep_start = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_count = '0; b_sweep_start = 0; b_out_ready = 0;
        dirv = '{0, 1, 63, 64, 65, 127};
        lit  = '{64'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        satv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_therm", a_out_therm, 64'd0);
        chk("rst_out_flags", 64'({a_out_sat, a_out_last}), 64'd0);
        chk("rst_sweep_busy", 64'(a_sweep_busy), 64'd0);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;

        // Direct decode and saturation, one word per cycle, 1-cycle latency
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i < 6) begin
                a_in_valid = 1'b1;
                a_in_count = 7'(dirv[i]);
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 6) chk("direct_in_ready", 64'(a_in_ready), 64'd1);
            if (i > 0) begin
                chk("direct_lat_valid", 64'(a_out_valid), 64'd1);
                chk("direct_therm", a_out_therm, lit[i-1]);
                chk("direct_sat", 64'(a_out_sat), 64'(satv[i-1]));
            end
        end
        repeat (3) @(posedge clk);

        // Backpressure: counts 0..9 with out_ready pattern 1,0,0,1
        idx = 0; cyc = 0; saw_full = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_count = 7'd0;
        while (cyc < 200 && !(idx == 10 && qa.size() == 0)) begin
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (a_in_valid && !a_in_ready) saw_full = 1'b1;
            @(posedge clk); #1;
            if (acc) idx++;
            a_in_valid  = (idx < 10);
            a_in_count  = 7'(idx);
            cyc++;
            a_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        end
        chk("bp_finished", 64'(cyc < 200), 64'd1);
        chk("bp_in_ready_dropped", 64'(saw_full), 64'd1);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (2) @(posedge clk);

        // Sweep start coinciding with a direct acceptance, then a start while busy
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_count = 7'd5; a_sweep_start = 1'b1;
        @(negedge clk);
        chk("coll_accept", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_sweep_start = 1'b0;
        @(negedge clk);
        chk("coll_direct_valid", 64'(a_out_valid), 64'd1);
        chk("coll_direct_first", a_out_therm, 64'h1F);
        repeat (5) @(posedge clk); #1;
        a_sweep_start = 1'b1;
        @(negedge clk);
        chk("coll_busy_at_restart", 64'(a_sweep_busy), 64'd1);
        @(posedge clk); #1;
        a_sweep_start = 1'b0;
        cyc = 0;
        while (cyc < 300 && (qa.size() != 0 || a_sweep_busy)) begin
            @(negedge clk);
            cyc++;
        end
        chk("coll_sweep_done", 64'(cyc < 300), 64'd1);
        repeat (8) @(negedge clk);
        chk("coll_idle", 64'(a_sweep_busy), 64'd0);

        // Sweep N=8, step 3: codes 0,3,6,8
        @(posedge clk); #1;
        b_sweep_start = 1'b1;
        @(posedge clk); #1;
        b_sweep_start = 1'b0;
        nb = 0; lastn = -1; cyc = 0;
        while (cyc < 50 && lastn < 0) begin
            @(negedge clk);
            cyc++;
            if (b_out_valid && b_out_ready) begin
                if (nb < 4) got[nb] = b_out_therm;
                if (b_out_last) lastn = nb;
                nb++;
            end
        end
        chk("b_word_count", 64'(nb), 64'd4);
        chk("b_last_index", 64'(lastn), 64'd3);
        chk("b_word0", 64'(got[0]), 64'h00);
        chk("b_word1", 64'(got[1]), 64'h07);
        chk("b_word2", 64'(got[2]), 64'h3F);
        chk("b_word3", 64'(got[3]), 64'hFF);
        @(negedge clk);
        chk("b_busy_after_last", 64'(b_sweep_busy), 64'd1);
        @(negedge clk);
        chk("b_busy_fall", 64'(b_sweep_busy), 64'd0);

        // Reset in the middle of a stalled sweep
        @(posedge clk); #1;
        a_sweep_start = 1'b1;
        @(posedge clk); #1;
        a_sweep_start = 1'b0;
        nb = 0; cyc = 0;
        while (cyc < 50 && nb < 3) begin
            @(negedge clk);
            cyc++;
            if (a_out_valid && a_out_ready) nb++;
        end
        chk("rst_pre_words", 64'(nb), 64'd3);
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_mid_busy", 64'(a_sweep_busy), 64'd0);
        a_out_ready = 1'b1;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_out_valid) nb++;
        end
        chk("rst_no_residual", 64'(nb), 64'd0);

        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
